viterbi_control: RTL and testbench
==================================

Name: viterbi_control

Overview:
- Timing and sequencing controller for the Viterbi decoder.
- From the single master clock it derives two quadrature phase clocks, Clock1 and Clock2, at one quarter of the master rate.
- It steps the add-compare-select (ACS) segment and page counters and issues the Init, Hold, CompareStart and TB_EN strobes to the ACS, survivor-memory and traceback blocks.

Parameters:
- WD_FSM, 6: width of ACSSegment; one page is 2^WD_FSM segments.
- WD_DEPTH, 4: width of ACSPage; survivor memory depth is 2^WD_DEPTH pages.

Ports:
- CLOCK  in  1  master clock; all logic on the rising edge.
- Reset  in  1  synchronous reset, active-high.
- Active  in  1  decoding enable.
- Clock1  out  1  phase clock A, CLOCK/4, registered.
- Clock2  out  1  phase clock B, CLOCK/4, lags Clock1 by one CLOCK cycle, registered.
- ACSPage  out  WD_DEPTH  current survivor-memory page.
- ACSSegment  out  WD_FSM  current ACS segment.
- CompareStart  out  1  survivor memory has been filled once.
- Hold  out  1  last segment of the page.
- Init  out  1  first segment of the page.
- TB_EN  out  1  traceback enable.

Behaviour:
- Only clock: CLOCK. Reset is synchronous and active-high; it is sampled on the CLOCK rising edge.
- Reset high: phase counter = 0, ACSSegment = 0, ACSPage = 0, and every 1-bit output = 0. Reset dominates Active.
- A 2-bit phase counter increments modulo 4 every CLOCK cycle, independent of Active.
- Clock1 = 1 in phases 0 and 1.
- Clock2 = 1 in phases 1 and 2.
- Both phase clocks are registered, so each is 2 cycles high and 2 cycles low, and Clock2 lags Clock1 by exactly 1 CLOCK cycle.
- Step event: phase == 3 and Active == 1. On a step:
  - ACSSegment increments, wrapping from 2^WD_FSM-1 to 0.
  - When ACSSegment wraps, ACSPage increments in the same cycle, wrapping from 2^WD_DEPTH-1 to 0.
- Active low: segment and page counters freeze at their current values; no reload.
- Init = Active and (ACSSegment == 0). Combinational from registered state.
- Hold = Active and (ACSSegment == 2^WD_FSM-1). Combinational from registered state.
- CompareStart:
  - Sticky. Set on the step where ACSPage wraps from 2^WD_DEPTH-1 to 0.
  - Cleared only by Reset; page wraps later do not affect it.
- TB_EN = registered (CompareStart and Active). It lags by one CLOCK cycle.
- Reset asserted mid-operation: every counter and output returns to its reset value on the next edge. CompareStart is lost and must refill.
- Active dropped exactly at phase 3: no step occurs.
- Latency from reset release to the first step: 4 CLOCK cycles, given Active = 1.

Optional Feature:
- Macro: CONTROL_CLK_GATE_EN.
- Defined: Clock1 and Clock2 are forced to 0 while Active = 0. The phase counter keeps running, so phase alignment is kept when Active returns.
- Undefined: Clock1 and Clock2 run free regardless of Active.

Decomposition:
- Shared package: WD_FSM and WD_DEPTH defaults, the phase encoding constants PH0..PH3, and the derived SEG_MAX and PAGE_MAX constants.
- One sub-module, viterbi_phase_gen: 2-bit phase counter plus registered Clock1/Clock2, emitting a step_tick at phase 3.
- Counters and strobes stay in the top.

Test Plan:
- Reset held 2 cycles with Active = 0, then Reset = 0: every output is 0.
  - Clock1 pattern 1,1,0,0 repeating.
  - Clock2 pattern 0,1,1,0 repeating.
- Active = 1 after reset:
  - ACSSegment increments every 4 cycles.
  - Init = 1 for the first 4 cycles.
  - Hold = 1 during ACSSegment = 63.
  - ACSPage = 1 after 256 cycles.
- Active = 1 for 4096 cycles: ACSPage returns to 0 and CompareStart rises; TB_EN rises 1 cycle later.
- Active = 0 for 40 cycles at ACSSegment = 10: ACSSegment stays at 10 and Init/Hold/TB_EN are 0. Restoring Active resumes counting at 11.
- Reset = 1 pulse with CompareStart = 1 and ACSPage = 3: on the next edge all outputs and counters are 0.
- Build with CONTROL_CLK_GATE_EN and Active = 0: Clock1 = Clock2 = 0. Raising Active restores the phase-aligned pattern.

Source files
------------

// File: rtl/viterbi_control_pkg.sv
// ============================================================================
//  Module   : viterbi_control_pkg
//  Brief    : Shared widths, phase encodings and derived limits for the
//             Viterbi decoder timing controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_control_pkg;

    // Default widths: segment counter and survivor-memory page counter
    localparam int WD_FSM_DEFAULT   = 6;
    localparam int WD_DEPTH_DEFAULT = 4;

    // Phase counter encodings; a step happens only in PH3
    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    // Largest value representable in a counter of the given width
    function automatic int max_of(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int SEG_MAX  = max_of(WD_FSM_DEFAULT);
    localparam int PAGE_MAX = max_of(WD_DEPTH_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/viterbi_phase_gen.sv
// ============================================================================
//  Module   : viterbi_phase_gen
//  Brief    : 2-bit phase counter producing two registered quadrature phase
//             clocks at CLOCK/4 and a step tick in phase 3.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_phase_gen
    import viterbi_control_pkg::*;
(
    input  logic CLOCK,
    input  logic Reset,
    input  logic gate,
    output logic clock1,
    output logic clock2,
    output logic step_tick
);

    logic [1:0] r_phase;
    logic       r_clock1;
    logic       r_clock2;

    // Free-running phase counter; the phase clocks are decoded from the
    // current phase and registered, so they trail the phase by one cycle
    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            r_phase  <= PH0;
            r_clock1 <= 1'b0;
            r_clock2 <= 1'b0;
        end else begin
            r_phase  <= r_phase + 2'd1;
            r_clock1 <= gate && ((r_phase == PH0) || (r_phase == PH1));
            r_clock2 <= gate && ((r_phase == PH1) || (r_phase == PH2));
        end
    end

    assign clock1    = r_clock1;
    assign clock2    = r_clock2;
    assign step_tick = (r_phase == PH3);

endmodule

`default_nettype wire

// File: rtl/viterbi_control.sv
// ============================================================================
//  Module   : viterbi_control
//  Brief    : Viterbi decoder timing controller. Derives the phase clocks,
//             steps the ACS segment/page counters and issues the Init, Hold,
//             CompareStart and TB_EN strobes.
//  Options  : CONTROL_CLK_GATE_EN - when defined, Clock1/Clock2 are held low
//             while Active is low (phase counter keeps running).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_control
    import viterbi_control_pkg::*;
#(
    parameter int WD_FSM   = WD_FSM_DEFAULT,
    parameter int WD_DEPTH = WD_DEPTH_DEFAULT
) (
    input  logic                CLOCK,
    input  logic                Reset,
    input  logic                Active,
    output logic                Clock1,
    output logic                Clock2,
    output logic [WD_DEPTH-1:0] ACSPage,
    output logic [WD_FSM-1:0]   ACSSegment,
    output logic                CompareStart,
    output logic                Hold,
    output logic                Init,
    output logic                TB_EN
);

    localparam logic [WD_FSM-1:0]   c_SEG_MAX  = WD_FSM'(max_of(WD_FSM));
    localparam logic [WD_DEPTH-1:0] c_PAGE_MAX = WD_DEPTH'(max_of(WD_DEPTH));
    localparam logic [WD_FSM-1:0]   c_SEG_ONE  = WD_FSM'(1);
    localparam logic [WD_DEPTH-1:0] c_PAGE_ONE = WD_DEPTH'(1);

    logic                w_gate;
    logic                w_step_tick;
    logic                w_step;
    logic                w_seg_wrap;
    logic                w_page_wrap;
    logic [WD_FSM-1:0]   r_segment;
    logic [WD_DEPTH-1:0] r_page;
    logic                r_compare_start;
    logic                r_tb_en;

`ifdef CONTROL_CLK_GATE_EN
    assign w_gate = Active;
`else
    assign w_gate = 1'b1;
`endif

    viterbi_phase_gen u_phase_gen (
        .CLOCK     (CLOCK),
        .Reset     (Reset),
        .gate      (w_gate),
        .clock1    (Clock1),
        .clock2    (Clock2),
        .step_tick (w_step_tick)
    );

    assign w_step      = w_step_tick && Active;
    assign w_seg_wrap  = (r_segment == c_SEG_MAX);
    assign w_page_wrap = (r_page == c_PAGE_MAX);

    // Segment/page counters advance once per phase cycle; CompareStart latches
    // on the first full pass through survivor memory and holds until reset
    always_ff @(posedge CLOCK) begin
        if (Reset) begin
            r_segment       <= '0;
            r_page          <= '0;
            r_compare_start <= 1'b0;
            r_tb_en         <= 1'b0;
        end else begin
            if (w_step) begin
                r_segment <= r_segment + c_SEG_ONE;
                if (w_seg_wrap) begin
                    r_page <= r_page + c_PAGE_ONE;
                    if (w_page_wrap) begin
                        r_compare_start <= 1'b1;
                    end
                end
            end
            r_tb_en <= r_compare_start && Active;
        end
    end

    assign ACSSegment   = r_segment;
    assign ACSPage      = r_page;
    assign CompareStart = r_compare_start;
    assign TB_EN        = r_tb_en;

    // Page-boundary strobes; masked during reset so every 1-bit output is low
    // while Reset is held even if Active is high
    assign Init = Active && !Reset && (r_segment == '0);
    assign Hold = Active && !Reset && w_seg_wrap;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_control.sv
// ============================================================================
//  Module   : tb_viterbi_control
//  Brief    : Self-checking bench for viterbi_control (table vectors plus
//             directed multi-cycle sequences).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_control;

`ifdef CONTROL_CLK_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic       CLOCK;
    logic       Reset;
    logic       Active;
    logic       Clock1;
    logic       Clock2;
    logic [3:0] ACSPage;
    logic [5:0] ACSSegment;
    logic       CompareStart;
    logic       Hold;
    logic       Init;
    logic       TB_EN;

    int n_total = 0;
    int n_pass  = 0;
    int k;

    viterbi_control #(.WD_FSM(6), .WD_DEPTH(4)) dut (
        .CLOCK        (CLOCK),
        .Reset        (Reset),
        .Active       (Active),
        .Clock1       (Clock1),
        .Clock2       (Clock2),
        .ACSPage      (ACSPage),
        .ACSSegment   (ACSSegment),
        .CompareStart (CompareStart),
        .Hold         (Hold),
        .Init         (Init),
        .TB_EN        (TB_EN)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic       rst;
        logic       act;
        logic       c1;
        logic       c2;
        logic [3:0] page;
        logic [5:0] seg;
        logic       init;
        logic       hold;
        logic       cs;
        logic       tb;
    } vec_t;

    vec_t vecs[16];

    // Observed outputs packed as {c1,c2,page,seg,init,hold,cs,tb}
    function automatic logic [15:0] observe();
        return {Clock1, Clock2, ACSPage, ACSSegment, Init, Hold, CompareStart, TB_EN};
    endfunction

    // Expected outputs k edges after reset release; act is Active at that edge
    function automatic logic [15:0] mk(input int kk, input bit act, input int seg,
                                       input int page, input bit init, input bit hold,
                                       input bit cs, input bit tb);
        logic c1, c2;
        c1 = ((kk % 4 == 1) || (kk % 4 == 2)) && (act || !GATE);
        c2 = ((kk % 4 == 2) || (kk % 4 == 3)) && (act || !GATE);
        return {c1, c2, 4'(page), 6'(seg), init, hold, cs, tb};
    endfunction

    // Continuous Active=1 run: one step every 4 edges
    function automatic logic [15:0] exp_run(input int kk);
        int seg;
        seg = (kk / 4) % 64;
        return mk(kk, 1'b1, seg, (kk / 256) % 16, seg == 0, seg == 63,
                  kk >= 4096, kk >= 4097);
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got={c1,c2,pg,seg,in,ho,cs,tb}=%b expected %b", name, got, want);
    endtask

    task automatic tick(input logic rst, input logic act);
        @(negedge CLOCK);
        Reset  = rst;
        Active = act;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        Reset  = 1'b1;
        Active = 1'b0;

        //            rst   act   c1    c2    page  seg   init  hold  cs    tb
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset, phase clock patterns, first steps, Active dropped in phase 3
        for (int i = 0; i < 16; i++) begin
            logic [15:0] want;
            tick(vecs[i].rst, vecs[i].act);
            want = {vecs[i].c1 && (vecs[i].act || !GATE),
                    vecs[i].c2 && (vecs[i].act || !GATE),
                    vecs[i].page, vecs[i].seg, vecs[i].init, vecs[i].hold,
                    vecs[i].cs, vecs[i].tb};
            check($sformatf("vec%0d", i), observe(), want);
        end

        // Long Active=1 run: segment/page wrap, Hold, CompareStart, TB_EN
        for (k = 1; k <= 4870; k++) begin
            tick(1'b0, 1'b1);
            if (k == 1 || k == 3 || k == 4 || k == 5 || k == 252 || k == 255 ||
                k == 256 || k == 257 || k == 4095 || k == 4096 || k == 4097 || k == 4870)
                check($sformatf("run_k%0d", k), observe(), exp_run(k));
        end

        // Reset with CompareStart set and page 3: everything clears
        tick(1'b1, 1'b1);
        check("reset_mid", observe(), 16'h0000);

        // Freeze at segment 10 while Active is low, then resume
        for (k = 1; k <= 41; k++) begin
            tick(1'b0, 1'b1);
            if (k == 40) check("pre_freeze_k40", observe(), exp_run(k));
        end
        for (k = 42; k <= 81; k++) begin
            tick(1'b0, 1'b0);
            if (k == 60 || k == 81)
                check($sformatf("freeze_k%0d", k), observe(),
                      mk(k, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        for (k = 82; k <= 84; k++) begin
            tick(1'b0, 1'b1);
            check($sformatf("resume_k%0d", k), observe(),
                  mk(k, 1'b1, (k == 84) ? 11 : 10, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
